// File: rtl/lector_contadores.sv
// ============================================================================
//  Module      : lector_contadores
//  Description : Scans counters 0..N_CNT-1, captures each count (or a timeout
//                marker) and streams (idx, count) words over valid/ready.
//                Optional accumulator: define LECTOR_SUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lector_contadores #(
    parameter int CNT_W   = 5,
    parameter int N_CNT   = 4,
    parameter int TIMEOUT = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDLE,
    input  logic             start,
    input  logic             valid_contador,
    input  logic [CNT_W-1:0] contador_out,
    output logic             req,
    output logic [1:0]       idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_idx,
    output logic [CNT_W-1:0] out_data,
    output logic             out_err,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic [CNT_W+1:0] sum_total
);

    localparam logic [2:0] C_WAIT = 3'd0;
    localparam logic [2:0] C_REQ  = 3'd1;
    localparam logic [2:0] C_CAPT = 3'd2;
    localparam logic [2:0] C_PUSH = 3'd3;
    localparam logic [2:0] C_DONE = 3'd4;

    localparam logic [1:0] C_LAST_IDX = 2'(N_CNT - 1);
    localparam logic [3:0] C_TIMEOUT  = 4'(TIMEOUT);

    logic [2:0]       r_state;
    logic [1:0]       r_i;
    logic [3:0]       r_timer;
    logic             r_req;
    logic [1:0]       r_idx;
    logic             r_out_valid;
    logic [1:0]       r_out_idx;
    logic [CNT_W-1:0] r_out_data;
    logic             r_out_err;
    logic             r_busy;
    logic             r_done;
    logic             r_abort;

    logic w_start;
    logic w_abort;
    logic w_xfer;

    assign w_start = (r_state == C_WAIT) && start && IDLE;
    assign w_abort = !IDLE && ((r_state == C_REQ) || (r_state == C_CAPT) || (r_state == C_PUSH));
    // Abort takes priority over a same-cycle handshake.
    assign w_xfer  = (r_state == C_PUSH) && IDLE && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= C_WAIT;
            r_i         <= 2'd0;
            r_timer     <= 4'd0;
            r_req       <= 1'b0;
            r_idx       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_idx   <= 2'd0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            if (w_abort) begin
                r_state     <= C_WAIT;
                r_i         <= 2'd0;
                r_req       <= 1'b0;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
                r_abort     <= 1'b1;
            end else begin
                case (r_state)
                    C_WAIT: begin
                        if (w_start) begin
                            r_state <= C_REQ;
                            r_i     <= 2'd0;
                            r_req   <= 1'b1;
                            r_idx   <= 2'd0;
                            r_busy  <= 1'b1;
                        end
                    end
                    C_REQ: begin
                        r_state <= C_CAPT;
                        r_req   <= 1'b0;
                        r_timer <= 4'd0;
                    end
                    C_CAPT: begin
                        if (valid_contador) begin
                            r_state     <= C_PUSH;
                            r_out_data  <= contador_out;
                            r_out_err   <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_idx   <= r_i;
                        end else begin
                            r_timer <= r_timer + 4'd1;
                            if ((r_timer + 4'd1) == C_TIMEOUT) begin
                                r_state     <= C_PUSH;
                                r_out_data  <= '0;
                                r_out_err   <= 1'b1;
                                r_out_valid <= 1'b1;
                                r_out_idx   <= r_i;
                            end
                        end
                    end
                    C_PUSH: begin
                        if (w_xfer) begin
                            r_out_valid <= 1'b0;
                            if (r_i == C_LAST_IDX) begin
                                r_state <= C_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= C_REQ;
                                r_i     <= r_i + 2'd1;
                                r_req   <= 1'b1;
                                r_idx   <= r_i + 2'd1;
                            end
                        end
                    end
                    C_DONE: begin
                        r_state <= C_WAIT;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= C_WAIT;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LECTOR_SUM_EN
    logic [CNT_W+1:0] r_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else if (w_start) begin
            r_sum <= '0;
        end else if (w_xfer) begin
            r_sum <= r_sum + {2'b00, r_out_data};
        end
    end

    assign sum_total = r_sum;
`else
    assign sum_total = '0;
`endif

    assign req       = r_req;
    assign idx       = r_idx;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign busy      = r_busy;
    assign done      = r_done;
    assign abort     = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_lector_contadores.sv
// ============================================================================
//  Module      : tb_lector_contadores
//  Description : Self-checking bench for lector_contadores against a
//                scan-level reference model and a registered counter model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lector_contadores;

    localparam int CNT_W   = 5;
    localparam int TIMEOUT = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             IDLE;
    logic             start;
    logic             valid_contador;
    logic [CNT_W-1:0] contador_out;
    logic             req;
    logic [1:0]       idx;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_idx;
    logic [CNT_W-1:0] out_data;
    logic             out_err;
    logic             busy;
    logic             done;
    logic             abort;
    logic [CNT_W+1:0] sum_total;

    lector_contadores #(.CNT_W(CNT_W), .N_CNT(4), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .IDLE           (IDLE),
        .start          (start),
        .valid_contador (valid_contador),
        .contador_out   (contador_out),
        .req            (req),
        .idx            (idx),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_idx        (out_idx),
        .out_data       (out_data),
        .out_err        (out_err),
        .busy           (busy),
        .done           (done),
        .abort          (abort),
        .sum_total      (sum_total)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int counts [4];
    bit stuck  [4];

    // Counter block model: answers a request one cycle later unless stuck.
    always @(posedge clk) begin
        valid_contador <= req && !stuck[idx];
        contador_out   <= 5'(counts[idx]);
    end

    int got_idx[$];
    int got_data[$];
    int got_err[$];
    int req_q[$];
    int done_cnt;
    int abort_cnt;
    int cyc;
    int req_t [4];
    int val_t [4];

    // Handshake rule: a word moves when valid & ready and no abort (IDLE high).
    always @(posedge clk) begin
        if (reset && out_valid && out_ready && IDLE) begin
            got_idx.push_back(int'(out_idx));
            got_data.push_back(int'(out_data));
            got_err.push_back(int'(out_err));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (req) begin
            req_q.push_back(int'(idx));
            req_t[idx] = cyc;
        end
        if (out_valid && val_t[out_idx] < 0) val_t[out_idx] = cyc;
        if (done)  done_cnt++;
        if (abort) abort_cnt++;
    endtask

    task automatic clear_obs();
        got_idx.delete(); got_data.delete(); got_err.delete(); req_q.delete();
        done_cnt = 0; abort_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            req_t[k] = -1;
            val_t[k] = -1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, req, 0);
        chk({tag, "_idx"}, idx, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_err"}, out_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_abort"}, abort, 0);
        chk({tag, "_sum"}, sum_total, 0);
    endtask

    // Full scan: expected words come from the count table and the stuck mask.
    task automatic run_scan(input string tag, input int stall_idx, input int stall_len,
                            input bit poke_start);
        int exp_sum;
        int stall_cnt;
        bit finished;
        exp_sum   = 0;
        stall_cnt = 0;
        finished  = 0;
        for (int k = 0; k < 4; k++) exp_sum += stuck[k] ? 0 : counts[k];
        clear_obs();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            start = (poke_start && c == 2);
            if (out_valid && int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
                if (stall_cnt > 0) begin
                    chk({tag, "_stall_valid"}, out_valid, 1);
                    chk({tag, "_stall_data"}, out_data, stuck[stall_idx] ? 0 : counts[stall_idx]);
                    chk({tag, "_stall_noreq"}, req_q.size(), stall_idx + 1);
                end
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (done_cnt > 0) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_finished"}, finished, 1);
        `ifdef LECTOR_SUM_EN
        chk({tag, "_sum"}, sum_total, exp_sum);
        `else
        chk({tag, "_sum"}, sum_total, 0);
        `endif
        chk({tag, "_nwords"}, got_idx.size(), 4);
        chk({tag, "_nreq"}, req_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_idx.size()) begin
                chk({tag, "_widx"}, got_idx[k], k);
                chk({tag, "_wdata"}, got_data[k], stuck[k] ? 0 : counts[k]);
                chk({tag, "_werr"}, got_err[k], stuck[k] ? 1 : 0);
            end
            if (k < req_q.size()) chk({tag, "_reqidx"}, req_q[k], k);
            chk({tag, "_latency"}, val_t[k] - req_t[k], stuck[k] ? TIMEOUT + 1 : 2);
        end
        tick();
        chk({tag, "_busy_after"}, busy, 0);
        tick();
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_no_abort"}, abort_cnt, 0);
    endtask

    initial begin
        cyc = 0;
        reset = 1'b0; IDLE = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin counts[k] = 0; stuck[k] = 0; end
        clear_obs();
        #2;
        check_all_zero("reset");
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("post_reset_busy", busy, 0);

        // Directed scan 3,0,17,31
        counts = '{3, 0, 17, 31};
        run_scan("basic", -1, 0, 0);

        // Backpressure on idx 2 plus a start pulse while busy
        run_scan("stall", 2, 5, 1);

        // Stuck counter at idx 1
        stuck[1] = 1;
        run_scan("timeout", -1, 0, 0);
        stuck[1] = 0;

        // start with IDLE low is ignored
        clear_obs();
        IDLE = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("idle_low_busy", busy, 0);
        chk("idle_low_req", req_q.size(), 0);
        IDLE = 1'b1;

        // IDLE drops during PUSH of idx 1, same cycle as out_ready
        begin
            bit hit;
            hit = 0;
            clear_obs();
            counts = '{5, 9, 2, 1};
            out_ready = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (out_valid && out_idx == 2'd1) begin
                    hit = 1;
                    break;
                end
                out_ready = out_valid && out_idx == 2'd0;
            end
            chk("abort_reached_push", hit, 1);
            IDLE = 1'b0; out_ready = 1'b1;
            tick();
            chk("abort_pulse", abort, 1);
            chk("abort_valid_drop", out_valid, 0);
            chk("abort_busy", busy, 0);
            IDLE = 1'b1; out_ready = 1'b0;
            tick();
            chk("abort_one_cycle", abort, 0);
            chk("abort_words", got_idx.size(), 1);
            chk("abort_no_done", done_cnt, 0);
            run_scan("after_abort", -1, 0, 0);
        end

        // Asynchronous reset while stuck in CAPT
        clear_obs();
        stuck[0] = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("pre_reset_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        reset = 1'b1;
        stuck[0] = 0;
        tick();
        chk("reset_release_busy", busy, 0);
        run_scan("after_reset", -1, 0, 0);

        // Randomized scans
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                counts[k] = int'($urandom_range(0, 31));
                stuck[k]  = ($urandom_range(0, 4) == 0);
            end
            run_scan("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
